// File: rtl/gb_link_peer_pkg.sv
// Shared constants for the Game Boy link-cable peer: FSM encodings and the idle fill byte.
package gb_link_peer_pkg;

  typedef logic [7:0] link_byte_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_MSHIFT = 2'd2;

  localparam link_byte_t IDLE_BYTE = 8'hFF;

  // A byte that starts with nothing queued sends all ones, like an idle GB line.
  function automatic link_byte_t next_tx_byte(input logic full, input link_byte_t hold);
    return full ? hold : IDLE_BYTE;
  endfunction

endpackage

// File: rtl/gb_link_peer_if.sv
// Host-side byte handshake of the link peer; master = host/emulated peripheral, slave = link engine.
interface gb_link_peer_if;
  logic       mode_master;
  logic       start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       timeout;

  modport master (
    output mode_master, start, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, timeout
  );

  modport slave (
    input  mode_master, start, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, timeout
  );
endinterface

// File: rtl/gb_link_peer_sync.sv
// Two-flop synchroniser for the GB serial clock and data (identical latency), with clock edge pulses.
module gb_link_peer_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_link_clk,
  input  logic i_link_data,
  output logic o_data,
  output logic o_clk_rise,
  output logic o_clk_fall
);
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic       r_clk_prev;

  // Bit 1 carries the clock, bit 0 the data; both lines idle high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta     <= 2'b11;
      r_sync     <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_meta     <= {i_link_clk, i_link_data};
      r_sync     <= r_meta;
      r_clk_prev <= r_sync[1];
    end
  end

  assign o_data     = r_sync[0];
  assign o_clk_rise = r_sync[1] & ~r_clk_prev;
  assign o_clk_fall = ~r_sync[1] & r_clk_prev;
endmodule

// File: rtl/gb_link_peer.sv
// Game Boy link-cable peer: exchanges one byte MSB-first, following the GB clock (slave) or driving it (master).
module gb_link_peer
  import gb_link_peer_pkg::*;
#(
  parameter int CLK_DIV   = 511,
  parameter int TIMEOUT_W = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  gb_link_peer_if.slave host,
  input  logic          i_link_clk_in,
  input  logic          i_link_data_in,
  output logic          o_link_clk_out,
  output logic          o_link_data_out
);
  // state     | meaning
  // ST_IDLE   | no byte in flight; slave waits for a GB falling edge, master for start
  // ST_SHIFT  | slave byte, bits move on synced GB clock edges, idle timer armed
  // ST_MSHIFT | master byte, divider paces the clock we drive to the GB

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 + 1);

  logic [1:0]           r_state;
  link_byte_t           r_hold;
  logic                 r_hold_full;
  link_byte_t           r_sr;
  logic [2:0]           r_cnt;
  logic [DIV_W-1:0]     r_div;
  logic [TIMEOUT_W-1:0] r_idle;
  link_byte_t           r_rx_data;
  logic                 r_rx_valid;
  logic                 r_timeout;
  logic                 r_clk_out;
  logic                 r_data_out;

  logic       w_data_in;
  logic       w_clk_rise;
  logic       w_clk_fall;
  logic       w_load;
  logic       w_slave_start;
  logic       w_master_start;
  logic       w_byte_start;
  logic       w_last_bit;
  link_byte_t w_next_byte;
  link_byte_t w_shifted;

  gb_link_peer_sync u_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_link_clk  (i_link_clk_in),
    .i_link_data (i_link_data_in),
    .o_data      (w_data_in),
    .o_clk_rise  (w_clk_rise),
    .o_clk_fall  (w_clk_fall)
  );

  assign w_load         = host.tx_valid && !r_hold_full;
  assign w_slave_start  = (r_state == ST_IDLE) && !host.mode_master && w_clk_fall;
  assign w_master_start = (r_state == ST_IDLE) && host.mode_master && host.start;
  assign w_byte_start   = w_slave_start || w_master_start;
  assign w_next_byte    = next_tx_byte(r_hold_full, r_hold);
  assign w_shifted      = {r_sr[6:0], w_data_in};
  assign w_last_bit     = (r_cnt == 3'd7);

  // A write can only land while the hold is empty, so it never races the start-of-byte clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold      <= host.tx_data;
      r_hold_full <= 1'b1;
    end else if (w_byte_start) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_sr       <= IDLE_BYTE;
      r_cnt      <= 3'd0;
      r_div      <= '0;
      r_idle     <= '0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_timeout  <= 1'b0;
      r_clk_out  <= 1'b1;
      r_data_out <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idle <= '0;
          if (w_slave_start) begin
            r_sr       <= w_next_byte;
            r_data_out <= w_next_byte[7];
            r_cnt      <= 3'd0;
            r_state    <= ST_SHIFT;
          end else if (w_master_start) begin
            r_sr    <= w_next_byte;
            r_div   <= DIV_MAX;
            r_cnt   <= 3'd0;
            r_state <= ST_MSHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_clk_rise || w_clk_fall) r_idle <= '0;
          else                          r_idle <= r_idle + TIMEOUT_W'(1);
          if (w_clk_fall) begin
            r_data_out <= r_sr[7];
          end else if (w_clk_rise) begin
            r_sr  <= w_shifted;
            r_cnt <= r_cnt + 3'd1;
            if (w_last_bit) begin
              r_rx_data  <= w_shifted;
              r_rx_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end else if (&r_idle) begin
            // GB stopped clocking mid-byte: drop the partial byte and release the data line.
            r_timeout  <= 1'b1;
            r_cnt      <= 3'd0;
            r_data_out <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        ST_MSHIFT: begin
          r_div <= r_div - DIV_W'(1);
          if (r_div == DIV_HALF) begin
            r_clk_out  <= 1'b0;
            r_data_out <= r_sr[7];
          end
          if (r_div == '0) begin
            r_sr      <= w_shifted;
            r_clk_out <= 1'b1;
            r_cnt     <= r_cnt + 3'd1;
            r_div     <= DIV_MAX;
            if (w_last_bit) begin
              r_rx_data  <= w_shifted;
              r_rx_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign host.tx_ready   = !r_hold_full;
  assign host.rx_data    = r_rx_data;
  assign host.rx_valid   = r_rx_valid;
  assign host.busy       = (r_state != ST_IDLE);
  assign host.timeout    = r_timeout;
  assign o_link_clk_out  = r_clk_out;
  assign o_link_data_out = r_data_out;
endmodule

// File: tb/tb_gb_link_peer.sv
// Directed bench for gb_link_peer: GB-side driver, master loopback, scoreboard monitor on rx_valid/timeout.
module tb_gb_link_peer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link_clk_in = 1'b1;
  logic data_drv = 1'b1;
  logic loop_en = 1'b0;
  logic link_data_in;
  logic link_clk_out;
  logic link_data_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       is_to;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  gb_link_peer_if bus ();

  assign link_data_in = loop_en ? link_data_out : data_drv;

  gb_link_peer #(.CLK_DIV(511), .TIMEOUT_W(10)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .host            (bus),
    .i_link_clk_in   (link_clk_in),
    .i_link_data_in  (link_data_in),
    .o_link_clk_out  (link_clk_out),
    .o_link_data_out (link_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    exp_t e;
    e.is_to = 1'b0;
    e.data  = b;
    sb.push_back(e);
  endtask

  task automatic push_to();
    exp_t e;
    e.is_to = 1'b1;
    e.data  = 8'h00;
    sb.push_back(e);
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // GB-style internal clock: data changes with the falling edge, peer output sampled just before rising.
  task automatic gb_bits(input logic [7:0] din, input int nbits,
                         output logic [7:0] seen, output logic rdy_all);
    seen    = 8'h00;
    rdy_all = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      link_clk_in = 1'b0;
      data_drv    = din[7-i];
      repeat (256) @(negedge clk);
      seen    = {seen[6:0], link_data_out};
      rdy_all = rdy_all & bus.tx_ready;
      link_clk_in = 1'b1;
      repeat (255) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_ready"}, bus.tx_ready, 1);
    check({tag, "_rx_data"}, bus.rx_data, 8'h00);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_clk_out"}, link_clk_out, 1);
    check({tag, "_data_out"}, link_data_out, 1);
  endtask

  // Scoreboard monitor: every rx_valid or timeout pulse consumes one expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.rx_valid || bus.timeout)) begin
        check("rx_to_exclusive", bus.rx_valid & bus.timeout, 0);
        check("sb_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("event_kind", bus.timeout, e.is_to);
          if (!e.is_to) check("rx_data", bus.rx_data, e.data);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seen;
    logic       rdy;
    logic       prev;
    int         falls;
    int         lows;
    int         lat;

    bus.mode_master = 1'b0;
    bus.start       = 1'b0;
    bus.tx_data     = 8'h00;
    bus.tx_valid    = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Slave byte: send 0xA5, receive 0x3C.
    tx_write(8'hA5);
    check("hold_full_ready", bus.tx_ready, 0);
    push_rx(8'h3C);
    gb_bits(8'h3C, 8, seen, rdy);
    check("slave_tx_bits", seen, 8'hA5);
    check("slave_ready_after", bus.tx_ready, 1);
    check("slave_busy_after", bus.busy, 0);

    // Slave byte with empty hold sends 0xFF.
    push_rx(8'h96);
    gb_bits(8'h96, 8, seen, rdy);
    check("empty_hold_bits", seen, 8'hFF);
    check("empty_hold_ready", rdy, 1);

    // Master loopback 0x81; write 0x42 and pulse start mid-byte (start must be ignored).
    bus.mode_master = 1'b1;
    loop_en = 1'b1;
    tx_write(8'h81);
    push_rx(8'h81);
    @(negedge clk);
    bus.start = 1'b1;
    falls = 0; lows = 0; lat = 0; prev = 1'b1;
    for (int i = 1; i <= 4400; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 300) begin bus.tx_data = 8'h42; bus.tx_valid = 1'b1; end
      if (i == 301) bus.tx_valid = 1'b0;
      if (i == 1000) bus.start = 1'b1;
      if (i == 1001) bus.start = 1'b0;
      if (i == 2000) check("master_busy_mid", bus.busy, 1);
      if (!link_clk_out && prev) falls++;
      if (!link_clk_out) lows++;
      prev = link_clk_out;
      if (bus.rx_valid && lat == 0) lat = i;
    end
    check("master_clk_pulses", falls, 8);
    check("master_low_cycles", lows, 2048);
    check("master_latency", lat, 4097);
    check("master_hold_kept", bus.tx_ready, 0);
    check("master_busy_after", bus.busy, 0);

    // Second master byte carries the held 0x42.
    push_rx(8'h42);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("master2_hold_taken", bus.tx_ready, 1);
    repeat (4200) @(negedge clk);

    // start in slave mode is ignored.
    bus.mode_master = 1'b0;
    loop_en = 1'b0;
    data_drv = 1'b1;
    tx_write(8'h11);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    falls = 0; prev = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!link_clk_out && prev) falls++;
      prev = link_clk_out;
    end
    check("slave_start_pulses", falls, 0);
    check("slave_start_busy", bus.busy, 0);
    check("slave_start_hold", bus.tx_ready, 0);

    // Slave timeout after 3 bits of 0x11, then a clean 0x55 byte.
    gb_bits(8'hF0, 3, seen, rdy);
    check("to_partial_bits", seen[2:0], 3'b000);
    push_to();
    repeat (1200) @(negedge clk);
    check("to_busy", bus.busy, 0);
    check("to_data_out", link_data_out, 1);
    push_rx(8'h55);
    gb_bits(8'h55, 8, seen, rdy);
    check("after_to_bits", seen, 8'hFF);

    // Reset after 4 bits of 0x77: no rx_valid, outputs at reset values.
    tx_write(8'h77);
    gb_bits(8'hAA, 4, seen, rdy);
    check("rst_partial_bits", seen[3:0], 4'h7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    push_rx(8'hC3);
    gb_bits(8'hC3, 8, seen, rdy);
    check("after_rst_bits", seen, 8'hFF);

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
